// File: rtl/llsc_if.sv
// Bundle between the MEM stage and the LL/SC reservation monitor.
// The master modport is the pipeline side and the slave modport is the monitor.
interface llsc_if #(
  parameter int CNT_W = 16
) ();
  logic             en;
  logic             flush;
  logic             mem_ll;
  logic             mem_sc;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic             snoop_valid;
  logic [31:0]      snoop_addr;
  logic             atomic_ex;
  logic [29:0]      link_addr;
  logic             mem_sc_mask;
  logic [31:0]      sc_result;
  logic             sc_result_valid;
  logic [CNT_W-1:0] sc_fail_count;
  logic             fsm_state;

  // MEM-stage inputs are sampled only while en=1. There is no backpressure.
  // sc_result is qualified by a single-cycle sc_result_valid pulse.
  modport master (
    output en, flush, mem_ll, mem_sc, mem_we, mem_addr, snoop_valid, snoop_addr,
    input  atomic_ex, link_addr, mem_sc_mask, sc_result, sc_result_valid,
           sc_fail_count, fsm_state
  );
  modport slave (
    input  en, flush, mem_ll, mem_sc, mem_we, mem_addr, snoop_valid, snoop_addr,
    output atomic_ex, link_addr, mem_sc_mask, sc_result, sc_result_valid,
           sc_fail_count, fsm_state
  );
endinterface

// File: rtl/llsc_monitor.sv
// Single-word LL/SC reservation monitor. It decides whether each SC may write
// and returns the 1/0 SC result. Stores, snoops, flush and timeout kill the link.
module llsc_monitor #(
  parameter int LINK_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic  clk,
  input  logic  rst,
  llsc_if.slave bus
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LINKED = 1'b1;

  localparam int              TW         = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (LINK_TIMEOUT != 0);
  localparam logic [TW-1:0]   TIMER_LAST = TW'((LINK_TIMEOUT > 0) ? LINK_TIMEOUT - 1 : 0);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             load_link;
  logic [29:0]      link_q;
  logic [TW-1:0]    timer;
  logic [31:0]      res_q;
  logic             res_v_q;
  logic [CNT_W-1:0] fail_q;

  logic linked;
  logic match_m;
  logic match_s;
  logic snoop_ll;
  logic sc_fire;
  logic sc_ok;
  logic timeout;

  assign linked   = (state == LINKED);
  assign match_m  = (bus.mem_addr[31:2] == link_q);
  assign match_s  = bus.snoop_valid & (bus.snoop_addr[31:2] == link_q);
  assign snoop_ll = bus.snoop_valid & (bus.snoop_addr[31:2] == bus.mem_addr[31:2]);
  assign sc_fire  = bus.en & bus.mem_sc & ~bus.flush;
  assign sc_ok    = sc_fire & linked & match_m & ~match_s;
  assign timeout  = TIMEOUT_EN & linked & (timer == TIMER_LAST);

  always_comb begin
    state_nxt = state;
    load_link = 1'b0;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else if (bus.en && bus.mem_sc) begin
      state_nxt = IDLE;
    end else if (bus.en && bus.mem_ll && !snoop_ll) begin
      state_nxt = LINKED;
      load_link = 1'b1;
    end else if (bus.en && bus.mem_ll) begin
      // A snoop hitting the LL word in the same cycle may have been missed, so do not link.
      state_nxt = IDLE;
    end else if (linked && match_s) begin
      state_nxt = IDLE;
    end else if (linked && bus.en && bus.mem_we && match_m) begin
      state_nxt = IDLE;
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      link_q  <= '0;
      timer   <= '0;
      res_q   <= '0;
      res_v_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      state   <= state_nxt;
      res_v_q <= sc_fire;
      if (load_link) begin
        link_q <= bus.mem_addr[31:2];
        timer  <= '0;
      end else if (linked) begin
        timer  <= timer + 1'b1;
      end
      if (sc_fire) begin
        res_q <= {31'b0, sc_ok};
      end
      if (sc_fire && !sc_ok && (fail_q != '1)) begin
        fail_q <= fail_q + 1'b1;
      end
    end
  end

  assign bus.atomic_ex       = linked;
  assign bus.link_addr       = link_q;
  assign bus.mem_sc_mask     = bus.mem_sc & ~sc_ok;
  assign bus.sc_result       = res_q;
  assign bus.sc_result_valid = res_v_q;
  assign bus.sc_fail_count   = fail_q;
  assign bus.fsm_state       = state;
endmodule

// File: tb/tb_llsc_monitor.sv
// Bench for llsc_monitor. Two DUTs (timeout 4 / 2-bit counter, and timeout off / 16-bit counter)
// share one stimulus stream. A reference model pushes expectations into queues that negedge monitors pop.
module tb_llsc_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llsc_if #(.CNT_W(2))  a_if ();
  llsc_if #(.CNT_W(16)) b_if ();

  llsc_monitor #(.LINK_TIMEOUT(4), .CNT_W(2))  dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  llsc_monitor #(.LINK_TIMEOUT(0), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  typedef struct {
    logic        ae;
    logic [29:0] la;
    logic        mask;
    logic        rv;
    int          fc;
  } cyc_t;

  cyc_t        cyc_q0[$];
  cyc_t        cyc_q1[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one slot per DUT
  bit          m_linked [2];
  logic [29:0] m_laddr  [2];
  int          m_age    [2];
  int          m_fails  [2];
  bit          m_rv     [2];
  int          to_p     [2] = '{4, 0};
  int          cmax     [2] = '{3, 65535};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_cycle(input int i, input bit r, input bit e, input bit f, input bit ll,
                             input bit sc, input bit we, input logic [31:0] a, input bit sv,
                             input logic [31:0] sa);
    bit   wm, ws, sl, ok, was, fire;
    int   age0;
    cyc_t c;
    wm   = (a[31:2] == m_laddr[i]);
    ws   = sv && (sa[31:2] == m_laddr[i]);
    sl   = sv && (sa[31:2] == a[31:2]);
    ok   = e && sc && m_linked[i] && wm && !ws && !f;
    fire = e && sc && !f;
    c.ae = m_linked[i]; c.la = m_laddr[i]; c.mask = sc && !ok; c.rv = m_rv[i]; c.fc = m_fails[i];
    if (i == 0) cyc_q0.push_back(c); else cyc_q1.push_back(c);
    if (r) begin
      m_linked[i] = 0; m_laddr[i] = '0; m_age[i] = 0; m_fails[i] = 0; m_rv[i] = 0;
      return;
    end
    m_rv[i] = fire;
    if (fire) begin
      if (i == 0) exp_q0.push_back({31'b0, ok}); else exp_q1.push_back({31'b0, ok});
      if (!ok && m_fails[i] < cmax[i]) m_fails[i]++;
    end
    was  = m_linked[i];
    age0 = m_age[i];
    if (was) m_age[i]++;
    if (f)                          m_linked[i] = 0;
    else if (e && sc)               m_linked[i] = 0;
    else if (e && ll && !sl) begin  m_linked[i] = 1; m_laddr[i] = a[31:2]; m_age[i] = 0; end
    else if (e && ll)               m_linked[i] = 0;
    else if (was && ws)             m_linked[i] = 0;
    else if (was && e && we && wm)  m_linked[i] = 0;
    else if (was && to_p[i] != 0 && age0 == to_p[i] - 1) m_linked[i] = 0;
  endtask

  task automatic step(input bit r, input bit e, input bit f, input bit ll, input bit sc,
                      input bit we, input logic [31:0] a, input bit sv, input logic [31:0] sa);
    @(posedge clk);
    #1;
    rst = r;
    a_if.en = e; a_if.flush = f; a_if.mem_ll = ll; a_if.mem_sc = sc; a_if.mem_we = we;
    a_if.mem_addr = a; a_if.snoop_valid = sv; a_if.snoop_addr = sa;
    b_if.en = e; b_if.flush = f; b_if.mem_ll = ll; b_if.mem_sc = sc; b_if.mem_we = we;
    b_if.mem_addr = a; b_if.snoop_valid = sv; b_if.snoop_addr = sa;
    model_cycle(0, r, e, f, ll, sc, we, a, sv, sa);
    model_cycle(1, r, e, f, ll, sc, we, a, sv, sa);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask
  task automatic do_ll(input logic [31:0] a);
    step(0, 1, 0, 1, 0, 0, a, 0, 32'h0);
  endtask
  task automatic do_sc(input logic [31:0] a);
    step(0, 1, 0, 0, 1, 1, a, 0, 32'h0);
  endtask
  task automatic do_sw(input logic [31:0] a);
    step(0, 1, 0, 0, 0, 1, a, 0, 32'h0);
  endtask

  task automatic mon(input int i, input logic ae, input logic [29:0] la, input logic mask,
                     input logic rv, input logic [31:0] res, input logic [31:0] fc, input logic st);
    cyc_t        c;
    logic [31:0] er;
    string       p;
    p = (i == 0) ? "a." : "b.";
    if (i == 0) begin
      if (cyc_q0.size() == 0) return;
      c = cyc_q0.pop_front();
    end else begin
      if (cyc_q1.size() == 0) return;
      c = cyc_q1.pop_front();
    end
    chk({p, "atomic_ex"}, {31'b0, ae}, {31'b0, c.ae});
    chk({p, "fsm_state"}, {31'b0, st}, {31'b0, c.ae});
    chk({p, "link_addr"}, {2'b0, la}, {2'b0, c.la});
    chk({p, "mem_sc_mask"}, {31'b0, mask}, {31'b0, c.mask});
    chk({p, "sc_result_valid"}, {31'b0, rv}, {31'b0, c.rv});
    chk({p, "sc_fail_count"}, fc, c.fc);
    if (rv === 1'b1) begin
      if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
        n_checks++;
        $display("FAIL %ssc_result: got pulse %h, expected no pulse", p, res);
      end else begin
        er = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk({p, "sc_result"}, res, er);
      end
    end
  endtask

  always @(negedge clk) begin
    assert (!(a_if.mem_ll === 1'b1 && a_if.mem_sc === 1'b1));
    mon(0, a_if.atomic_ex, a_if.link_addr, a_if.mem_sc_mask, a_if.sc_result_valid,
        a_if.sc_result, {30'b0, a_if.sc_fail_count}, a_if.fsm_state);
    mon(1, b_if.atomic_ex, b_if.link_addr, b_if.mem_sc_mask, b_if.sc_result_valid,
        b_if.sc_result, {16'b0, b_if.sc_fail_count}, b_if.fsm_state);
  end

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    case ($urandom_range(0, 2))
      0:       base = 32'h100;
      1:       base = 32'h200;
      default: base = 32'h300;
    endcase
    return base + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    a_if.en = 0; a_if.flush = 0; a_if.mem_ll = 0; a_if.mem_sc = 0; a_if.mem_we = 0;
    a_if.mem_addr = 0; a_if.snoop_valid = 0; a_if.snoop_addr = 0;
    b_if.en = 0; b_if.flush = 0; b_if.mem_ll = 0; b_if.mem_sc = 0; b_if.mem_we = 0;
    b_if.mem_addr = 0; b_if.snoop_valid = 0; b_if.snoop_addr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_linked[i] = 0; m_laddr[i] = '0; m_age[i] = 0; m_fails[i] = 0; m_rv[i] = 0;
    end
    idle(1);

    // basic pair
    do_ll(32'h100); idle(1); do_sc(32'h100); idle(1);
    // intervening store, same word then different word
    do_ll(32'h100); do_sw(32'h102); do_sc(32'h100); idle(1);
    do_ll(32'h100); do_sw(32'h104); do_sc(32'h100); idle(1);
    // snoop kills link; snoop in the SC cycle
    do_ll(32'h200); step(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h203); idle(1);
    do_ll(32'h200); step(0, 1, 0, 0, 1, 1, 32'h200, 1, 32'h200); idle(1);
    // LL with snoop to the same word
    step(0, 1, 0, 1, 0, 0, 32'h300, 1, 32'h301); idle(1); do_sc(32'h300);
    // timeout boundary
    do_ll(32'h300); idle(3); idle(1); idle(1); do_sc(32'h300); idle(1);
    // stalled SC then advance
    do_ll(32'h400);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 1, 32'h400, 0, 32'h0);
    do_sc(32'h400); idle(1);
    // flush with LL, flush with SC
    step(0, 1, 1, 1, 0, 0, 32'h100, 0, 32'h0); idle(1);
    do_ll(32'h100); step(0, 1, 1, 0, 1, 1, 32'h100, 0, 32'h0); idle(2);
    // re-link to a new address
    do_ll(32'h100); do_ll(32'h200); do_sc(32'h100); idle(1);
    // reset while linked
    do_ll(32'h100); step(1, 1, 0, 0, 0, 0, 32'h0, 0, 32'h0); idle(2);
    // counter saturation
    for (int k = 0; k < 5; k++) do_sc(32'h500);
    idle(2);
    // long hold: only the timeout-free DUT keeps the link
    do_ll(32'h500); idle(10000); do_sc(32'h500); idle(1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit r, e, f, ll, sc, we, sv;
      int op;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 19);
      ll = (op < 3);
      sc = (op >= 3 && op < 6);
      we = sc || (op >= 6 && op < 10);
      sv = ($urandom_range(0, 6) == 0);
      step(r, e, f, ll, sc, we, pick_addr(), sv, pick_addr());
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("a.leftover_results", exp_q0.size(), 0);
    chk("b.leftover_results", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
